// File: rtl/rx_ltssm_qualifier_if.sv
// ---------------------------------------------------------------------------
// rx_ltssm_qualifier_if
//
// Bundles the request, per-lane ordered-set and verdict signals of the
// receive-side LTSSM qualifier. The LTSSM (or a testbench) uses the master
// modport and drives the request and lane inputs. The qualifier uses the
// slave modport and drives the verdict and status outputs.
//
// Signals:
//   substate         master->slave  4         requested substate (0..9)
//   laneMask         master->slave  MAXLANES  lanes that must qualify
//   osValid          master->slave  MAXLANES  ordered set completed this cycle
//   osMatch          master->slave  MAXLANES  completed set is the expected type
//   rxElectricalIdle master->slave  MAXLANES  per-lane electrical idle
//   finish           slave->master  1         one-cycle verdict strobe
//   passed           slave->master  1         verdict, valid with finish
//   exitTo           slave->master  4         next substate, valid with finish
//   busy             slave->master  1         qualifier is counting
//   osCheckEnable    slave->master  MAXLANES  lanes being checked
//   lanesQualified   slave->master  MAXLANES  per-lane threshold reached
// ---------------------------------------------------------------------------
interface rx_ltssm_qualifier_if #(
    parameter int MAXLANES = 16
);
    logic [3:0]          substate;
    logic [MAXLANES-1:0] laneMask;
    logic [MAXLANES-1:0] osValid;
    logic [MAXLANES-1:0] osMatch;
    logic [MAXLANES-1:0] rxElectricalIdle;
    logic                finish;
    logic                passed;
    logic [3:0]          exitTo;
    logic                busy;
    logic [MAXLANES-1:0] osCheckEnable;
    logic [MAXLANES-1:0] lanesQualified;

    modport master (
        output substate, laneMask, osValid, osMatch, rxElectricalIdle,
        input  finish, passed, exitTo, busy, osCheckEnable, lanesQualified
    );

    modport slave (
        input  substate, laneMask, osValid, osMatch, rxElectricalIdle,
        output finish, passed, exitTo, busy, osCheckEnable, lanesQualified
    );
endinterface

// File: rtl/rx_ltssm_qualifier.sv
// ---------------------------------------------------------------------------
// rx_ltssm_qualifier
//
// Receive-side qualifier that runs beside the LTSSM. A new substate request
// starts a count of consecutive matching ordered sets on every masked lane.
// The count is checked against a per-substate threshold while an internal
// timer runs down. A one-cycle finish pulse carries a pass/fail verdict and
// the next substate code. A change of substate while counting abandons the
// count silently.
//
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous reset, active low
//   bus    slave modport of rx_ltssm_qualifier_if (request, lanes, verdict)
//
// Optional feature macro: RX_LTSSM_EIDLE_EXIT_EN
//   When defined, detectQuiet passes as soon as any lane leaves electrical
//   idle. When undefined, rxElectricalIdle is not used and detectQuiet ends
//   only on timeout.
// ---------------------------------------------------------------------------
module rx_ltssm_qualifier #(
    parameter int MAXLANES = 16,
    parameter int CNT_W    = 4,
    parameter int TMR_W    = 24,
    parameter int T_QUIET  = 12,
    parameter int T_ACTIVE = 4,
    parameter int T_2      = 2,
    parameter int T_24     = 24,
    parameter int T_48     = 48
) (
    input logic                  clk,
    input logic                  reset,
    rx_ltssm_qualifier_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_PASS,
        S_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          lastState_q, lastState_d;
    logic [3:0]          curSub_q, curSub_d;
    logic [CNT_W-1:0]    thr_q, thr_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    cnt_q [MAXLANES];
    logic [CNT_W-1:0]    cnt_d [MAXLANES];
    logic                finish_q, finish_d;
    logic                passed_q, passed_d;
    logic [3:0]          exitTo_q, exitTo_d;
    logic                busy_q, busy_d;
    logic [MAXLANES-1:0] osCheckEnable_q, osCheckEnable_d;
    logic [MAXLANES-1:0] lanesQualified_q, lanesQualified_d;
    logic                allQual;

    function automatic logic [TMR_W-1:0] timeoutFor(input logic [3:0] s);
        case (s)
            4'd0:          return TMR_W'(T_QUIET);
            4'd1:          return TMR_W'(T_ACTIVE);
            4'd3:          return TMR_W'(T_48);
            4'd6, 4'd9:    return TMR_W'(T_2);
            default:       return TMR_W'(T_24);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] thresholdFor(input logic [3:0] s);
        case (s)
            4'd0, 4'd1:       return CNT_W'(0);
            4'd2, 4'd3, 4'd8: return CNT_W'(8);
            default:          return CNT_W'(2);
        endcase
    endfunction

    // An empty mask never qualifies; otherwise every masked lane must have
    // reached the threshold on the registered qualification vector.
    assign allQual = (bus.laneMask != '0) &&
                     ((bus.laneMask & ~lanesQualified_q) == '0);

    // Next-state logic. A substate change while counting has priority over
    // everything, then the timeout, then early exits.
    always_comb begin
        state_d     = state_q;
        lastState_d = lastState_q;
        curSub_d    = curSub_q;
        thr_d       = thr_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        finish_d    = 1'b0;
        passed_d    = 1'b0;
        exitTo_d    = 4'd0;

        case (state_q)
            S_IDLE: begin
                if ((bus.substate != lastState_q) && (bus.substate <= 4'd9)) begin
                    state_d  = S_COUNT;
                    curSub_d = bus.substate;
                    thr_d    = thresholdFor(bus.substate);
                    timer_d  = timeoutFor(bus.substate);
                    for (int i = 0; i < MAXLANES; i++) begin
                        cnt_d[i] = '0;
                    end
                end
            end

            S_COUNT: begin
                if (bus.substate != curSub_q) begin
                    state_d = S_IDLE;
                end else if (timer_q == '0) begin
                    finish_d = 1'b1;
                    if (curSub_q <= 4'd1) begin
                        state_d  = S_PASS;
                        passed_d = 1'b1;
                        exitTo_d = curSub_q + 4'd1;
                    end else begin
                        state_d  = S_FAIL;
                    end
`ifdef RX_LTSSM_EIDLE_EXIT_EN
                end else if ((curSub_q == 4'd0) && (bus.rxElectricalIdle != '1)) begin
                    state_d  = S_PASS;
                    finish_d = 1'b1;
                    passed_d = 1'b1;
                    exitTo_d = 4'd1;
`endif
                end else if ((curSub_q >= 4'd2) && allQual) begin
                    state_d  = S_PASS;
                    finish_d = 1'b1;
                    passed_d = 1'b1;
                    exitTo_d = curSub_q + 4'd1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                    // A mismatch breaks the run so only consecutive matches count.
                    for (int i = 0; i < MAXLANES; i++) begin
                        if (bus.laneMask[i] && bus.osValid[i]) begin
                            if (!bus.osMatch[i]) begin
                                cnt_d[i] = '0;
                            end else if (cnt_q[i] < thr_q) begin
                                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                            end
                        end
                    end
                end
            end

            S_PASS, S_FAIL: begin
                lastState_d = curSub_q;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d          = (state_d == S_COUNT);
        osCheckEnable_d = busy_d ? bus.laneMask : '0;
        for (int i = 0; i < MAXLANES; i++) begin
            lanesQualified_d[i] = busy_d && (cnt_d[i] >= thr_d);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            lastState_q      <= 4'hF;
            curSub_q         <= 4'd0;
            thr_q            <= '0;
            timer_q          <= '0;
            for (int i = 0; i < MAXLANES; i++) begin
                cnt_q[i] <= '0;
            end
            finish_q         <= 1'b0;
            passed_q         <= 1'b0;
            exitTo_q         <= 4'd0;
            busy_q           <= 1'b0;
            osCheckEnable_q  <= '0;
            lanesQualified_q <= '0;
        end else begin
            state_q          <= state_d;
            lastState_q      <= lastState_d;
            curSub_q         <= curSub_d;
            thr_q            <= thr_d;
            timer_q          <= timer_d;
            cnt_q            <= cnt_d;
            finish_q         <= finish_d;
            passed_q         <= passed_d;
            exitTo_q         <= exitTo_d;
            busy_q           <= busy_d;
            osCheckEnable_q  <= osCheckEnable_d;
            lanesQualified_q <= lanesQualified_d;
        end
    end

    assign bus.finish         = finish_q;
    assign bus.passed         = passed_q;
    assign bus.exitTo         = exitTo_q;
    assign bus.busy           = busy_q;
    assign bus.osCheckEnable  = osCheckEnable_q;
    assign bus.lanesQualified = lanesQualified_q;

endmodule
